// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One trial subtraction per clock (shift, subtract, restore). A start/done
// handshake lets datapath control issue divisions next to add/sub ops.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   rem_q;    // partial remainder, one guard bit
  logic [WIDTH-1:0] q_q;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvsr_q;   // divisor captured at acceptance
  logic [CW-1:0]    cnt;      // step index 0..WIDTH-1

  // One restoring step: shift {rem,q} left, trial-subtract, keep or restore.
  // The extra top bit on shifted/trial makes the borrow show up as a sign bit.
  logic [WIDTH+1:0] shifted, trial;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Combinational step datapath
  always_comb begin
    shifted = {rem_q, q_q[WIDTH-1]};
    trial   = shifted - {2'b00, dvsr_q};
    if (!trial[WIDTH+1]) begin
      rem_nxt = trial[WIDTH:0];
      q_nxt   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH:0];
      q_nxt   = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              // No iterations needed: report saturated quotient right away.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              rem_q  <= '0;
              q_q    <= dividend;
              dvsr_q <= divisor;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          q_q   <= q_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient    <= q_nxt;
            remainder   <= rem_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Start is not sampled here; a held start is taken one edge later.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (WIDTH=8).
module tb_seq_divider;

  localparam int W = 8;

  logic         clk, rst_n, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sbq[$];
  exp_t got;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer divide, saturated on zero divisor
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done q=%0d r=%0d dz=%0d", quotient, remainder, div_by_zero);
      end else begin
        got = sbq.pop_front();
        if ({quotient, remainder, div_by_zero} !== {got.q, got.r, got.dz}) begin
          errors++;
          $display("FAIL result got q=%0d r=%0d dz=%0d want q=%0d r=%0d dz=%0d",
                   quotient, remainder, div_by_zero, got.q, got.r, got.dz);
        end
      end
    end
  end

  // Issue one op (called #1 after a posedge with the DUT idle); checks latency
  // and busy length, returns #1 after the edge that leaves DONE.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
    int cyc, bcnt, want_cyc, want_b;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    sbq.push_back(model(a, b));
    want_cyc = (b == 0) ? 1 : W + 1;
    want_b   = (b == 0) ? 0 : W;
    cyc = 0; bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bcnt++;
    end while (done !== 1'b1 && cyc < 40);
    checks++;
    if (cyc != want_cyc) begin
      errors++;
      $display("FAIL %s_latency got %0d cycles want %0d", nm, cyc, want_cyc);
    end
    checks++;
    if (bcnt != want_b) begin
      errors++;
      $display("FAIL %s_busy got %0d cycles want %0d", nm, bcnt, want_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #3;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {busy, done, quotient, remainder, div_by_zero});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_normal();
    issue(200, 7, "normal");
    checks++;
    if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL normal_200_7 got q=%0d r=%0d dz=%0d want q=28 r=4 dz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_edges();
    issue(255, 1, "e255_1");
    issue(5, 9, "e5_9");
    issue(0, 5, "e0_5");
    issue(255, 255, "e255_255");
    checks++;
    if (quotient !== 8'd1 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL edge_hold got q=%0d r=%0d want q=1 r=0", quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    issue(100, 0, "dz");
    checks++;
    if (div_by_zero !== 1'b1 || quotient !== 8'd255 || remainder !== 8'd100) begin
      errors++;
      $display("FAIL dz_hold got q=%0d r=%0d dz=%0d want q=255 r=100 dz=1",
               quotient, remainder, div_by_zero);
    end
    issue(9, 3, "after_dz");
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear got %0d want 0", div_by_zero);
    end
  endtask

  task automatic test_ignored();
    int cyc, d0;
    d0 = done_cnt;
    start = 1'b1; dividend = 200; divisor = 7;
    @(posedge clk);
    sbq.push_back(model(200, 7));
    #1 dividend = 50; divisor = 5;        // start stays high
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 40);
    checks++;
    if (cyc != W + 1) begin
      errors++;
      $display("FAIL ignored_latency got %0d want %0d", cyc, W + 1);
    end
    dividend = 10; divisor = 0;
    sbq.push_back(model(10, 0));
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_gap done got %0d want 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignored_next_done got %0d want 1", done);
    end
    start = 1'b0;
    #1;
    checks++;
    if (done_cnt - d0 != 2) begin
      errors++;
      $display("FAIL ignored_pulses got %0d want 2", done_cnt - d0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    start = 1'b1; dividend = 200; divisor = 7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %b want 0", {busy, done, quotient, remainder, div_by_zero});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL midreset_no_done got %0d pulses want 0", done_cnt - d0);
    end
    issue(77, 10, "after_reset");
    checks++;
    if (quotient !== 8'd7 || remainder !== 8'd7) begin
      errors++;
      $display("FAIL after_reset_77_10 got q=%0d r=%0d want q=7 r=7", quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    int d0, bad;
    d0 = done_cnt; bad = 0;
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      issue(a, b, "sweep");
      checks++;
      if ((16'(quotient) * 16'(b) + 16'(remainder)) !== 16'(a) || remainder >= b) begin
        errors++;
        if (bad < 10)
          $display("FAIL sweep_invariant a=%0d b=%0d got q=%0d r=%0d", a, b, quotient, remainder);
        bad++;
      end
    end
    checks++;
    if (done_cnt - d0 != 2000) begin
      errors++;
      $display("FAIL sweep_pulses got %0d want 2000", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_edges();
    test_div_zero();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d entries want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
